// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the flagged FIFO family.
package fifo_pkg;

  // Pointer width for an index range of 0..depth-1. Never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width for a count range of 0..depth. Never narrower than 1 bit.
  function automatic int level_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Bundle of fifo_flagged signals. Names match the module ports one-to-one.
interface fifo_flagged_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input logic clock
);
  logic                          resetn;
  logic                          flush;
  logic                          push_enable;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          pop_enable;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          full;
  logic                          empty;
  logic                          almost_full;
  logic                          almost_empty;
  logic [level_width(DEPTH)-1:0] level;
  logic                          overflow;
  logic                          underflow;
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with level count, almost-full/empty thresholds, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_LEVEL  = 3,
  parameter int unsigned AEMPTY_LEVEL = 1,
  parameter bit          FWFT         = 1'b0
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          push_enable,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          pop_enable,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  push_ok, pop_ok, mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Accept/reject decisions, next pointers, level, flags and read register.
  always_comb begin
    pop_ok   = pop_enable && !empty_q;
    // A full FIFO still takes a push when the same cycle frees a slot.
    push_ok  = push_enable && (!full_q || pop_ok);
    wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    ovf_d    = ovf_q | (push_enable && !push_ok);
    unf_d    = unf_q | (pop_enable && empty_q);
    // Registered-pop mode presents the head only for the cycle after the pop.
    dout_d   = (!FWFT && pop_ok) ? rd_data : '0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dout_d   = '0;
    end
    full_d   = (level_d == DEPTH_L);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign mem_we = push_ok && resetn && !flush;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clock  (clock),
    .wr_en  (mem_we),
    .wr_addr(wr_ptr_q),
    .wr_data(data_in),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  // FWFT shows the head combinationally from the registered read pointer.
  assign data_out     = FWFT ? (empty_q ? '0 : rd_data) : dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: a registered-pop instance (dut0) and a
// FWFT instance (dut1) share one set of inputs.
module tb_fifo_flagged;
  import fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  fifo_flagged_if #(.DATA_WIDTH(8), .DEPTH(4)) bus (.clock(clk));

  logic [7:0] f1_dout;
  logic       f1_full, f1_empty, f1_afull, f1_aempty, f1_ovf, f1_unf;
  logic [2:0] f1_level;

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1'b0)) dut0 (
    .clock(clk), .resetn(bus.resetn), .flush(bus.flush),
    .push_enable(bus.push_enable), .data_in(bus.data_in), .pop_enable(bus.pop_enable),
    .data_out(bus.data_out), .full(bus.full), .empty(bus.empty),
    .almost_full(bus.almost_full), .almost_empty(bus.almost_empty), .level(bus.level),
    .overflow(bus.overflow), .underflow(bus.underflow)
  );

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1'b1)) dut1 (
    .clock(clk), .resetn(bus.resetn), .flush(bus.flush),
    .push_enable(bus.push_enable), .data_in(bus.data_in), .pop_enable(bus.pop_enable),
    .data_out(f1_dout), .full(f1_full), .empty(f1_empty),
    .almost_full(f1_afull), .almost_empty(f1_aempty), .level(f1_level),
    .overflow(f1_ovf), .underflow(f1_unf)
  );

  task automatic cyc(input logic push, input logic [7:0] din, input logic pop);
    @(negedge clk);
    bus.push_enable = push;
    bus.data_in     = din;
    bus.pop_enable  = pop;
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.push_enable = 1'b0;
    bus.pop_enable  = 1'b0;
    bus.flush       = 1'b1;
    @(posedge clk); #1;
    bus.flush       = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.resetn = 1'b1;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    tests++;
    if ({bus.data_out, bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.level, bus.overflow, bus.underflow}
        !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_dut0: dout=%h e=%b ae=%b f=%b af=%b lvl=%0d ov=%b un=%b, want 00 1 1 0 0 0 0 0",
               bus.data_out, bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.level, bus.overflow, bus.underflow);
    end
    tests++;
    if ({f1_dout, f1_empty, f1_aempty, f1_full, f1_level} !== {8'h00, 1'b1, 1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_dut1: dout=%h e=%b ae=%b f=%b lvl=%0d, want 00 1 1 0 0",
               f1_dout, f1_empty, f1_aempty, f1_full, f1_level);
    end
  endtask

  task automatic test_fill_overflow();
    logic [2:0] exp_lvl [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    for (int i = 0; i < 6; i++) begin
      cyc(1, 8'(i + 1), 0);
      tests++;
      if ({bus.level, bus.almost_full, bus.full, bus.almost_empty, bus.overflow, bus.data_out}
          !== {exp_lvl[i], exp_lvl[i] >= 3'd3, exp_lvl[i] == 3'd4, exp_lvl[i] <= 3'd1, i >= 4, 8'h00}) begin
        fails++;
        $display("FAIL fill_push%0d: lvl=%0d af=%b f=%b ae=%b ov=%b dout=%h, want lvl=%0d ov=%b dout=00",
                 i + 1, bus.level, bus.almost_full, bus.full, bus.almost_empty, bus.overflow, bus.data_out,
                 exp_lvl[i], i >= 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1);
      tests++;
      if ({bus.data_out, bus.level, bus.empty, bus.full} !== {8'(i + 1), 3'(3 - i), i == 3, 1'b0}) begin
        fails++;
        $display("FAIL drain_pop%0d: dout=%h lvl=%0d e=%b f=%b, want dout=%h lvl=%0d e=%b f=0",
                 i + 1, bus.data_out, bus.level, bus.empty, bus.full, 8'(i + 1), 3 - i, i == 3);
      end
    end
    cyc(0, 8'h00, 0);
    tests++;
    if ({bus.data_out, bus.overflow} !== {8'h00, 1'b1}) begin
      fails++;
      $display("FAIL drain_idle: dout=%h ov=%b, want 00 1", bus.data_out, bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_d [4] = '{8'd2, 8'd3, 8'd4, 8'd9};
    do_flush();
    for (int i = 0; i < 4; i++) cyc(1, 8'(i + 1), 0);
    cyc(1, 8'd9, 1);
    tests++;
    if ({bus.level, bus.full, bus.overflow, bus.data_out} !== {3'd4, 1'b1, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL full_push_pop: lvl=%0d f=%b ov=%b dout=%h, want 4 1 0 01",
               bus.level, bus.full, bus.overflow, bus.data_out);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1);
      tests++;
      if (bus.data_out !== exp_d[i]) begin
        fails++;
        $display("FAIL full_push_pop_drain%0d: dout=%h, want %h", i, bus.data_out, exp_d[i]);
      end
    end
  endtask

  task automatic test_underflow_flush();
    cyc(0, 8'h00, 1);
    tests++;
    if ({bus.underflow, bus.level, bus.data_out, bus.empty} !== {1'b1, 3'd0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL underflow: un=%b lvl=%0d dout=%h e=%b, want 1 0 00 1",
               bus.underflow, bus.level, bus.data_out, bus.empty);
    end
    do_flush();
    tests++;
    if ({bus.underflow, bus.overflow, bus.empty} !== {1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL flush_clears: un=%b ov=%b e=%b, want 0 0 1", bus.underflow, bus.overflow, bus.empty);
    end
  endtask

  task automatic test_wrap_scoreboard();
    logic [7:0] q [$];
    logic       ovf_m = 1'b0;
    logic       push, pop, push_ok, pop_ok;
    logic [7:0] exp_dout;
    logic [2:0] sz;
    int         bad = 0;
    for (int i = 0; i < 36; i++) begin
      push = (i % 3 != 2) && (i < 28);
      pop  = (i % 2 == 1) || (i >= 28);
      pop_ok  = pop && (q.size() > 0);
      push_ok = push && ((q.size() < 4) || pop_ok);
      exp_dout = pop_ok ? q[0] : 8'h00;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(8'(i + 16));
      if (push && !push_ok) ovf_m = 1'b1;
      sz = 3'(q.size());
      cyc(push, 8'(i + 16), pop);
      tests++;
      if ({bus.data_out, bus.level, bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.overflow}
          !== {exp_dout, sz, sz == 3'd4, sz == 3'd0, sz >= 3'd3, sz <= 3'd1, ovf_m}) begin
        fails++;
        bad++;
        if (bad < 6)
          $display("FAIL wrap_cycle%0d: dout=%h lvl=%0d f=%b e=%b af=%b ae=%b ov=%b, want dout=%h lvl=%0d ov=%b",
                   i, bus.data_out, bus.level, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                   bus.overflow, exp_dout, sz, ovf_m);
      end
    end
  endtask

  task automatic test_fwft();
    do_flush();
    cyc(1, 8'hA5, 0);
    tests++;
    if ({f1_dout, f1_empty, f1_level} !== {8'hA5, 1'b0, 3'd1}) begin
      fails++;
      $display("FAIL fwft_first: dout=%h e=%b lvl=%0d, want a5 0 1", f1_dout, f1_empty, f1_level);
    end
    cyc(0, 8'h00, 1);
    tests++;
    if ({f1_dout, f1_empty} !== {8'h00, 1'b1}) begin
      fails++;
      $display("FAIL fwft_pop_empty: dout=%h e=%b, want 00 1", f1_dout, f1_empty);
    end
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    cyc(1, 8'h33, 0);
    tests++;
    if ({f1_dout, f1_level, f1_afull} !== {8'h11, 3'd3, 1'b1}) begin
      fails++;
      $display("FAIL fwft_three: dout=%h lvl=%0d af=%b, want 11 3 1", f1_dout, f1_level, f1_afull);
    end
    cyc(0, 8'h00, 1);
    tests++;
    if ({f1_dout, f1_level} !== {8'h22, 3'd2}) begin
      fails++;
      $display("FAIL fwft_advance: dout=%h lvl=%0d, want 22 2", f1_dout, f1_level);
    end
    cyc(1, 8'h44, 0);
    @(negedge clk);
    bus.push_enable = 1'b0;
    bus.resetn      = 1'b0;
    @(posedge clk); #1;
    bus.resetn = 1'b1;
    tests++;
    if ({f1_level, f1_empty, f1_dout, f1_aempty} !== {3'd0, 1'b1, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL fwft_reset: lvl=%0d e=%b dout=%h ae=%b, want 0 1 00 1", f1_level, f1_empty, f1_dout, f1_aempty);
    end
  endtask

  initial begin
    bus.resetn      = 1'b0;
    bus.flush       = 1'b0;
    bus.push_enable = 1'b0;
    bus.pop_enable  = 1'b0;
    bus.data_in     = 8'h00;
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_underflow_flush();
    test_wrap_scoreboard();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
